// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : jk_bank_arbiter
// Purpose : round-robin shared access to a bank of JK-style flags
//           (set / clear / toggle of one bit per granted command)
// Revision: 1.0  initial release
// ============================================================================
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     q,
  output logic                 busy,
  output logic                 err
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [PTRW-1:0]   win_q, win_d;
  logic [1:0]        op_l_q, op_l_d;
  logic [IDXW-1:0]   idx_l_q, idx_l_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [PTRW-1:0]   pick;
  logic              found;
  logic [1:0]        pick_op;
  logic [IDXW-1:0]   pick_idx;

  // Round-robin search: first asserted request at or after ptr, with wrap.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        pick  = PTRW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    pick_op  = op[2*int'(pick) +: 2];
    pick_idx = idx[IDXW*int'(pick) +: IDXW];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_l_d  = op_l_q;
    idx_l_d = idx_l_q;
    q_d     = q_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = EXEC;
          win_d       = pick;
          op_l_d      = pick_op;
          idx_l_d     = pick_idx;
          // Outputs for the EXEC cycle are registered here so they never glitch.
          gnt_d[pick] = 1'b1;
          busy_d      = 1'b1;
          err_d       = (int'(pick_idx) >= WIDTH);
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (int'(idx_l_q) < WIDTH) begin
          case (op_l_q)
            2'b01:   q_d[idx_l_q] = 1'b0;
            2'b10:   q_d[idx_l_q] = 1'b1;
            2'b11:   q_d[idx_l_q] = ~q_q[idx_l_q];
            default: q_d[idx_l_q] = q_q[idx_l_q];
          endcase
        end
        ptr_d = (win_q == PTRW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Bank-wide clear overrides any command applied on the same edge.
    if (clr_all) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_l_q  <= '0;
      idx_l_q <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_l_q  <= op_l_d;
      idx_l_q <= idx_l_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = q_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// Bench for jk_bank_arbiter: an 8-bit and a 6-bit bank share one stimulus stream
// and are checked every cycle against a transaction-level model.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] idx;
  logic        clr_all;

  logic [3:0]  gnt8, gnt6;
  logic [7:0]  q8;
  logic [5:0]  q6;
  logic        busy8, busy6, err8, err6;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx), .clr_all(clr_all),
    .gnt(gnt8), .q(q8), .busy(busy8), .err(err8)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx), .clr_all(clr_all),
    .gnt(gnt6), .q(q6), .busy(busy6), .err(err6)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit         m_pend;
  int         m_w, m_ptr, m_idx;
  logic [1:0] m_op;
  logic [7:0] m_q8, m_q6;

  function automatic int pick_rr(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  function automatic logic [7:0] apply_op(logic [7:0] cur, logic [1:0] o, int ix, int w, logic clr);
    logic [7:0] n;
    n = cur;
    if (ix < w) begin
      case (o)
        2'b01:   n[ix] = 1'b0;
        2'b10:   n[ix] = 1'b1;
        2'b11:   n[ix] = ~n[ix];
        default: n = cur;
      endcase
    end
    if (clr) n = 8'h00;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_w    <= 0;
      m_ptr  <= 0;
      m_idx  <= 0;
      m_op   <= 2'b00;
      m_q8   <= 8'h00;
      m_q6   <= 8'h00;
    end else if (m_pend) begin
      m_q8   <= apply_op(m_q8, m_op, m_idx, 8, clr_all);
      m_q6   <= apply_op(m_q6, m_op, m_idx, 6, clr_all);
      m_ptr  <= (m_w + 1) % 4;
      m_pend <= 1'b0;
    end else begin
      if (clr_all) begin
        m_q8 <= 8'h00;
        m_q6 <= 8'h00;
      end
      if (|req) begin
        m_pend <= 1'b1;
        m_w    <= pick_rr(req, m_ptr);
        m_op   <= op[2*pick_rr(req, m_ptr) +: 2];
        m_idx  <= int'(idx[3*pick_rr(req, m_ptr) +: 3]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("gnt8",  32'(gnt8),  m_pend ? (32'd1 << m_w) : 32'd0);
      check("gnt6",  32'(gnt6),  m_pend ? (32'd1 << m_w) : 32'd0);
      check("busy8", 32'(busy8), 32'(m_pend));
      check("busy6", 32'(busy6), 32'(m_pend));
      check("err8",  32'(err8),  32'(m_pend && (m_idx >= 8)));
      check("err6",  32'(err6),  32'(m_pend && (m_idx >= 6)));
      check("q8",    32'(q8),    32'(m_q8));
      check("q6",    32'(q6),    32'(m_q6[5:0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input int r, input logic [1:0] o, input int ix);
    req = 4'b0000;
    op  = 8'h00;
    idx = 12'h000;
    req[r]        = 1'b1;
    op[2*r +: 2]  = o;
    idx[3*r +: 3] = 3'(ix);
  endtask

  task automatic do_cmd(input int r, input logic [1:0] o, input int ix);
    set_cmd(r, o, ix);
    step();
    req = 4'b0000;
    step();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    op      = 8'h00;
    idx     = 12'h000;
    clr_all = 1'b0;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      req = 4'($urandom);
      op  = 8'($urandom);
      idx = 12'($urandom);
      step();
      check("rst_q8", 32'(q8), 32'h0);
      check("rst_gnt8", 32'(gnt8), 32'h0);
    end
    req   = 4'b0000;
    op    = 8'h00;
    idx   = 12'h000;
    rst_n = 1'b1;
    step();

    // Single command: set bit 3 from requester 1, then toggle it back
    set_cmd(1, 2'b10, 3);
    step();
    check("single_gnt", 32'(gnt8), 32'h2);
    req = 4'b0000;
    step();
    check("single_gnt_drop", 32'(gnt8), 32'h0);
    check("single_q_set", 32'(q8), 32'h08);
    do_cmd(1, 2'b11, 3);
    check("single_q_tog", 32'(q8), 32'h00);

    // Fairness with all requesters holding; requester i toggles bit i
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    op  = 8'hFF;
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      step();
      check("fair_gnt", 32'(gnt8), (j % 2 == 0) ? (32'd1 << (j / 2)) : 32'd0);
    end
    req = 4'b0000;
    step();
    check("fair_q8", 32'(q8), 32'h0F);

    // Out-of-range index on the 6-bit bank, in range on the 8-bit bank
    set_cmd(0, 2'b10, 7);
    step();
    check("oor_err6", 32'(err6), 32'h1);
    check("oor_err8", 32'(err8), 32'h0);
    check("oor_gnt6", 32'(gnt6), 32'h1);
    req = 4'b0000;
    step();
    check("oor_q6", 32'(q6), 32'h0F);
    check("oor_q8", 32'(q8), 32'h8F);
    op  = 8'h00;
    req = 4'b1111;
    step();
    check("oor_ptr", 32'(gnt6), 32'h2);
    req = 4'b0000;
    step();

    // Fill the bank, then race clr_all against a set command
    for (int i = 0; i < 8; i++) do_cmd(i % 4, 2'b10, i);
    check("fill_q8", 32'(q8), 32'hFF);
    check("fill_q6", 32'(q6), 32'h3F);
    set_cmd(2, 2'b10, 0);
    step();
    check("clr_gnt", 32'(gnt8), 32'h4);
    req     = 4'b0000;
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    check("clr_q8", 32'(q8), 32'h00);
    check("clr_q6", 32'(q6), 32'h00);

    // Reset while a command is executing
    set_cmd(0, 2'b10, 5);
    step();
    check("rmid_gnt_pre", 32'(gnt8), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rmid_gnt", 32'(gnt8), 32'h0);
    check("rmid_busy", 32'(busy8), 32'h0);
    step();
    rst_n = 1'b1;
    req   = 4'b0000;
    step();
    check("rmid_q8", 32'(q8), 32'h00);
    op  = 8'h00;
    req = 4'b1111;
    step();
    check("rmid_ptr", 32'(gnt8), 32'h1);
    req = 4'b0000;
    step();
    step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
